shared_reg_arbiter: RTL and testbench
=====================================

// Module: shared_reg_arbiter
// PURPOSE
//  Round-robin arbiter that shares one WIDTH-bit D-type storage register between N_REQ
//  requesters. Each requester raises req with its write data. The arbiter grants one
//  requester, captures its data into the register and returns a one-cycle ack.
//  Sits between requester blocks and the shared register; q feeds downstream readers.
// PARAMETERS
//  WIDTH     8   data width of the shared register
//  N_REQ     4   number of requesters (2..8)
//  CNT_W     8   width of write counter wr_count (wraps)
// PORTS
//  clk       in   1             rising-edge clock; single clock domain
//  reset     in   1             synchronous, active-low reset (sampled on posedge clk)
//  req       in   N_REQ         per-requester write request, level, held until ack
//  wdata     in   N_REQ*WIDTH   flat write data; requester i at [i*WIDTH +: WIDTH]
//  grant     out  N_REQ         one-hot grant, registered; high only in GRANT state
//  ack       out  N_REQ         one-hot, one-cycle write-done pulse, registered
//  q         out  WIDTH         shared register contents
//  q_valid   out  1             1 once any write has completed since reset
//  busy      out  1             1 when state != IDLE
//  wr_count  out  CNT_W         completed writes, modulo 2**CNT_W
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, ptr=0, grant=0, ack=0, q=0, q_valid=0,
//   wr_count=0. Reset overrides everything mid-transaction; the in-flight write is lost.
//  FSM, 3 states:
//   IDLE : if |req: winner = first set req[] scanning ptr, ptr+1, ..., ptr-1 (mod N_REQ);
//          grant<=onehot(winner); -> GRANT. Else stay; grant=0.
//   GRANT: if req[winner]==1: q<=wdata[winner]; ack<=onehot(winner); q_valid<=1;
//          wr_count<=wr_count+1; ptr<=(winner+1) mod N_REQ; grant<=0; -> ACK.
//          If req[winner]==0 (withdrawn): no write, no ack, ptr unchanged,
//          grant<=0; -> IDLE.
//   ACK  : ack high this cycle only; req ignored; ack<=0 -> IDLE.
//  Timing: req seen in IDLE at edge E0 -> grant high E0..E1 -> q updated and ack high
//   E1..E2. Max throughput: one write per 3 cycles.
//  Requester rule: drop req in the ACK cycle, or keep it high to request again. A req still
//   high when IDLE is re-entered is a new request. Requests from other requesters remain
//   pending, not lost.
//  Fairness: ptr advances past the last winner. Any requester holding req waits at most
//   N_REQ-1 other writes.
//  Simultaneous req: resolved by rotating priority only; no fixed priority.
//  wdata is sampled only at the GRANT->ACK edge; it may change at other times.
//  wr_count wraps 2**CNT_W-1 -> 0 with no flag. grant and ack are never both nonzero.
// STRUCTURE
//  Package shared_reg_pkg: typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACK} state_t;
//   localparam MAX_REQ = 8.
//  Sub-module rr_picker (combinational): inputs req, ptr; outputs onehot winner and
//   winner index. Top holds the FSM, ptr, q, counters.
// TESTING
//  1 reset: reset=0 for 2 cycles with req=4'b1111 -> grant=0, ack=0, q=0, q_valid=0,
//    wr_count=0, busy=0.
//  2 single write: req=4'b0100, wdata[2]=8'hA5 -> grant=4'b0100 at cycle 1;
//    ack=4'b0100 and q=8'hA5 at cycle 2; wr_count=1, q_valid=1; idle by cycle 3.
//  3 round-robin: req=4'b1111 held, data i=8'h10+i -> ack order 0,1,2,3,0.
//    q follows 8'h10,11,12,13,10, one write every 3 cycles.
//  4 withdraw: req=4'b0010, drop it in the GRANT cycle -> no ack, q and wr_count
//    unchanged, ptr unchanged; next req=4'b0011 grants requester 1 first.
//  5 reset mid-op: assert reset=0 in the GRANT cycle with wdata=8'hFF -> q=0,
//    ack never pulses, state=IDLE.
//  6 wrap: CNT_W=2, perform 5 writes -> wr_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/shared_reg_pkg.sv
// Shared types and limits for the round-robin shared-register arbiter.
// Pointer width is sized for the largest supported requester count.
package shared_reg_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_ACK
    } state_t;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = $clog2(MAX_REQ);

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority picker: first set req at or after ptr.
// Candidates are ranked by their modular distance from ptr.
module rr_picker
    import shared_reg_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] winner_oh,
    output logic [IDX_W-1:0] winner_idx,
    output logic             any
);

    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        any        = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!any && req[i] &&
                    (((i - int'(ptr) + N_REQ) % N_REQ) == off)) begin
                    winner_oh[i] = 1'b1;
                    winner_idx   = IDX_W'(i);
                    any          = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register between N_REQ requesters.
// IDLE picks a winner, GRANT writes if the winner still requests, ACK pulses.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic                   busy,
    output logic [CNT_W-1:0]       wr_count
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               q_valid_q, q_valid_d;
    logic [CNT_W-1:0]   wr_count_q, wr_count_d;

    logic [N_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [N_REQ-1:0]   win_oh;
    logic               win_req;
    logic [WIDTH-1:0]   win_data;

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req        (req),
        .ptr        (ptr_q),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    // Decode the latched winner without variable indexing
    always_comb begin
        win_oh   = '0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_oh[i] = (win_q == IDX_W'(i));
            win_data  = win_data |
                        (wdata[i*WIDTH +: WIDTH] & {WIDTH{win_oh[i]}});
        end
        win_req = |(req & win_oh);
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        grant_d    = grant_q;
        ack_d      = ack_q;
        q_d        = q_q;
        q_valid_d  = q_valid_q;
        wr_count_d = wr_count_q;
        unique case (state_q)
            S_IDLE: begin
                grant_d = '0;
                ack_d   = '0;
                if (pick_any) begin
                    grant_d = pick_oh;
                    win_d   = pick_idx;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                grant_d = '0;
                if (win_req) begin
                    q_d        = win_data;
                    ack_d      = win_oh;
                    q_valid_d  = 1'b1;
                    wr_count_d = wr_count_q + CNT_W'(1);
                    ptr_d      = (win_q == IDX_W'(N_REQ - 1)) ?
                                 '0 : win_q + IDX_W'(1);
                    state_d    = S_ACK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACK: begin
                ack_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                ack_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            q_q        <= q_d;
            q_valid_q  <= q_valid_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign grant    = grant_q;
    assign ack      = ack_q;
    assign q        = q_q;
    assign q_valid  = q_valid_q;
    assign busy     = (state_q != S_IDLE);
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed table-driven bench for shared_reg_arbiter.
// A second instance with a 2-bit counter covers wr_count wrap.
module tb_shared_reg_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  grant, ack;
    logic [7:0]  q;
    logic        q_valid, busy;
    logic [7:0]  wr_count;

    logic [3:0]  req2;
    logic [31:0] wdata2;
    logic [3:0]  grant2, ack2;
    logic [7:0]  q2;
    logic        q_valid2, busy2;
    logic [1:0]  wr_count2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shared_reg_arbiter #(.WIDTH(8), .N_REQ(4), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .wdata    (wdata),
        .grant    (grant),
        .ack      (ack),
        .q        (q),
        .q_valid  (q_valid),
        .busy     (busy),
        .wr_count (wr_count)
    );

    shared_reg_arbiter #(.WIDTH(8), .N_REQ(4), .CNT_W(2)) dut_w (
        .clk      (clk),
        .reset    (reset),
        .req      (req2),
        .wdata    (wdata2),
        .grant    (grant2),
        .ack      (ack2),
        .q        (q2),
        .q_valid  (q_valid2),
        .busy     (busy2),
        .wr_count (wr_count2)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] wd;
        logic [3:0]  e_grant;
        logic [3:0]  e_ack;
        logic [7:0]  e_q;
        logic        e_qv;
        logic        e_busy;
        logic [7:0]  e_cnt;
    } vec_t;

    localparam logic [31:0] D  = 32'h13121110;
    localparam logic [31:0] DA = 32'h13A51110;

    vec_t tbl [29];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // reset held with all requests up
        tbl[0]  = '{1'b0, 4'b1111, D,  4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 4'b1111, D,  4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 8'd0};
        // single write by requester 2
        tbl[2]  = '{1'b1, 4'b0100, DA, 4'b0100, 4'b0000, 8'h00, 1'b0, 1'b1, 8'd0};
        tbl[3]  = '{1'b1, 4'b0100, DA, 4'b0000, 4'b0100, 8'hA5, 1'b1, 1'b1, 8'd1};
        tbl[4]  = '{1'b1, 4'b0000, DA, 4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b0, 8'd1};
        tbl[5]  = '{1'b0, 4'b0000, D,  4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 8'd0};
        // round robin with all four requesting
        tbl[6]  = '{1'b1, 4'b1111, D,  4'b0001, 4'b0000, 8'h00, 1'b0, 1'b1, 8'd0};
        tbl[7]  = '{1'b1, 4'b1111, D,  4'b0000, 4'b0001, 8'h10, 1'b1, 1'b1, 8'd1};
        tbl[8]  = '{1'b1, 4'b1111, D,  4'b0000, 4'b0000, 8'h10, 1'b1, 1'b0, 8'd1};
        tbl[9]  = '{1'b1, 4'b1111, D,  4'b0010, 4'b0000, 8'h10, 1'b1, 1'b1, 8'd1};
        tbl[10] = '{1'b1, 4'b1111, D,  4'b0000, 4'b0010, 8'h11, 1'b1, 1'b1, 8'd2};
        tbl[11] = '{1'b1, 4'b1111, D,  4'b0000, 4'b0000, 8'h11, 1'b1, 1'b0, 8'd2};
        tbl[12] = '{1'b1, 4'b1111, D,  4'b0100, 4'b0000, 8'h11, 1'b1, 1'b1, 8'd2};
        tbl[13] = '{1'b1, 4'b1111, D,  4'b0000, 4'b0100, 8'h12, 1'b1, 1'b1, 8'd3};
        tbl[14] = '{1'b1, 4'b1111, D,  4'b0000, 4'b0000, 8'h12, 1'b1, 1'b0, 8'd3};
        tbl[15] = '{1'b1, 4'b1111, D,  4'b1000, 4'b0000, 8'h12, 1'b1, 1'b1, 8'd3};
        tbl[16] = '{1'b1, 4'b1111, D,  4'b0000, 4'b1000, 8'h13, 1'b1, 1'b1, 8'd4};
        tbl[17] = '{1'b1, 4'b1111, D,  4'b0000, 4'b0000, 8'h13, 1'b1, 1'b0, 8'd4};
        tbl[18] = '{1'b1, 4'b1111, D,  4'b0001, 4'b0000, 8'h13, 1'b1, 1'b1, 8'd4};
        tbl[19] = '{1'b1, 4'b1111, D,  4'b0000, 4'b0001, 8'h10, 1'b1, 1'b1, 8'd5};
        tbl[20] = '{1'b1, 4'b0000, D,  4'b0000, 4'b0000, 8'h10, 1'b1, 1'b0, 8'd5};
        // withdraw in GRANT, then ptr still at 1
        tbl[21] = '{1'b1, 4'b0010, D,  4'b0010, 4'b0000, 8'h10, 1'b1, 1'b1, 8'd5};
        tbl[22] = '{1'b1, 4'b0000, D,  4'b0000, 4'b0000, 8'h10, 1'b1, 1'b0, 8'd5};
        tbl[23] = '{1'b1, 4'b0011, D,  4'b0010, 4'b0000, 8'h10, 1'b1, 1'b1, 8'd5};
        tbl[24] = '{1'b1, 4'b0011, D,  4'b0000, 4'b0010, 8'h11, 1'b1, 1'b1, 8'd6};
        tbl[25] = '{1'b1, 4'b0001, D,  4'b0000, 4'b0000, 8'h11, 1'b1, 1'b0, 8'd6};
        tbl[26] = '{1'b1, 4'b0001, D,  4'b0001, 4'b0000, 8'h11, 1'b1, 1'b1, 8'd6};
        tbl[27] = '{1'b1, 4'b0001, D,  4'b0000, 4'b0001, 8'h10, 1'b1, 1'b1, 8'd7};
        tbl[28] = '{1'b1, 4'b0000, D,  4'b0000, 4'b0000, 8'h10, 1'b1, 1'b0, 8'd7};

        reset  = 1'b0;
        req    = 4'b1111;
        wdata  = D;
        req2   = 4'b0000;
        wdata2 = 32'h0000003C;

        for (int i = 0; i < 29; i++) begin
            reset = tbl[i].rst;
            req   = tbl[i].req;
            wdata = tbl[i].wd;
            step();
            check($sformatf("row%0d grant", i), 32'(grant), 32'(tbl[i].e_grant));
            check($sformatf("row%0d ack", i), 32'(ack), 32'(tbl[i].e_ack));
            check($sformatf("row%0d q", i), 32'(q), 32'(tbl[i].e_q));
            check($sformatf("row%0d q_valid", i), 32'(q_valid), 32'(tbl[i].e_qv));
            check($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
            check($sformatf("row%0d wr_count", i), 32'(wr_count), 32'(tbl[i].e_cnt));
        end

        // reset arriving in the GRANT cycle drops the write
        req   = 4'b0100;
        wdata = 32'h00FF0000;
        step();
        check("rstmid grant", 32'(grant), 32'h4);
        reset = 1'b0;
        step();
        check("rstmid q", 32'(q), 32'h0);
        check("rstmid ack", 32'(ack), 32'h0);
        check("rstmid busy", 32'(busy), 32'h0);
        check("rstmid grant0", 32'(grant), 32'h0);
        check("rstmid cnt", 32'(wr_count), 32'h0);
        check("rstmid qv", 32'(q_valid), 32'h0);
        reset = 1'b1;
        req   = 4'b0000;
        step();
        check("rstmid ack2", 32'(ack), 32'h0);
        check("rstmid q2", 32'(q), 32'h0);
        check("rstmid busy2", 32'(busy), 32'h0);

        // 2-bit counter wraps 3 -> 0
        begin
            logic [1:0] exp_cnt [5];
            exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
            for (int k = 0; k < 5; k++) begin
                req2 = 4'b0001;
                step();
                check($sformatf("wrap%0d grant", k), 32'(grant2), 32'h1);
                step();
                check($sformatf("wrap%0d ack", k), 32'(ack2), 32'h1);
                check($sformatf("wrap%0d cnt", k), 32'(wr_count2), 32'(exp_cnt[k]));
                check($sformatf("wrap%0d q", k), 32'(q2), 32'h3C);
                req2 = 4'b0000;
                step();
                check($sformatf("wrap%0d busy", k), 32'(busy2), 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
